zxw_pm_loader: RTL and testbench
================================

Name: zxw_pm_loader

Overview:
- Switch-driven program-memory writer: the producer for the 14-bit instruction memory that the lab CPU fetches from.
- Operator enters each 14-bit instruction as three chunks on SW_pin, strobing Load_pin per chunk; block assembles the word and issues a one-cycle write to the program-memory write port.
- Holds the CPU in reset while loading; shows load progress on Display_pin.

Parameters:
ADDR_W, 10, program-memory address width (matches CPU PC[9:0]).
DEPTH, 1024, number of writable words; must be ≤ 2**ADDR_W.
SYNC_STAGES, 2, synchronizer flops on Load_pin and Mode_pin.

Ports:
Clock_pin  input  1  system clock; all state changes on rising edge.
Resetn_pin  input  1  reset, asynchronous, active-low.
SW_pin  input  5  chunk data; sampled only on a detected Load_pin rising edge.
Load_pin  input  1  asynchronous chunk strobe (button, already debounced).
Mode_pin  input  1  asynchronous level; 1 = load mode, 0 = run mode.
PM_addr  output  ADDR_W  program-memory write address.
PM_data  output  14  assembled instruction word.
PM_wr  output  1  write enable, one-cycle pulse.
Cpu_resetn  output  1  active-low CPU reset; low in load mode or while Resetn_pin low.
Display_pin  output  8  {Full, phase[1:0], PM_addr[4:0]}.

Behaviour:
- Reset (async, Resetn_pin=0): state IDLE; PM_addr=0, PM_data=0, PM_wr=0, Full=0, all sync flops 0, Display_pin=0, Cpu_resetn=0.
- Reset is asynchronous mid-operation: partial word discarded, no write issued.
- Synchronization:
  - Load_pin and Mode_pin each pass through SYNC_STAGES flops.
  - Load edge = synced value 1 AND previous synced value 0.
  - A chunk latches on the (SYNC_STAGES+1)th rising edge after Load_pin rises.
- Cpu_resetn = Resetn_pin AND NOT synced Mode. Purely combinational from these; no extra delay.
- State machine:
  - IDLE (phase 00): synced Mode rising edge → HI; PM_addr=0, Full=0.
  - HI (phase 01): load edge → PM_data[13:9]=SW_pin[4:0]; go to MID.
  - MID (phase 10): load edge → PM_data[8:4]=SW_pin[4:0]; go to LO.
  - LO (phase 11): load edge → PM_data[3:0]=SW_pin[3:0] (SW_pin[4] ignored); go to WRITE.
  - WRITE: PM_wr=1 for exactly this cycle; PM_addr and PM_data stable. Next cycle PM_wr=0 and go to HI.
  - Address update on leaving WRITE: if PM_addr==DEPTH-1, Full=1 and PM_addr stays; else PM_addr+1.
- Full=1: load edges ignored in HI; no further writes.
- Address never wraps silently.
- Synced Mode falls in any state except WRITE: go to IDLE immediately, partial word discarded, PM_addr/Full retained for display.
- Synced Mode falls in WRITE: the write completes, then go to IDLE.
- Load edge while in WRITE: ignored; it is not queued.
- Load edges in IDLE are ignored.
- PM_data holds the last assembled word between writes; its partial bits update per chunk.
- Display phase: 00 in IDLE, 01 in HI, 10 in MID, 11 in LO, and 11 in WRITE.

Test Plan:
1. Reset, then Mode_pin=1 and chunks 5'h04, 5'h00, 4'h2 → one PM_wr pulse with PM_addr=0, PM_data=14'h0802; PM_addr then 1; Cpu_resetn=0 throughout.
2. Three consecutive words 0x1FFF, 0x0000, 0x2AAA → PM_wr pulses at addresses 0, 1, 2 with those data values; Display_pin[4:0]=3 at end.
3. DEPTH=4: load 5 words → writes at addresses 0–3 only; Full=1, Display_pin[7]=1, PM_addr=3; 5th word produces no PM_wr.
4. Mode_pin dropped after two chunks → no PM_wr, state IDLE, Cpu_resetn=1 within SYNC_STAGES+1 cycles. Re-entry resets PM_addr to 0.
5. Load_pin held high 20 cycles → only one chunk is captured. A Load_pin pulse shorter than one clock but caught by a rising edge counts once.
6. Resetn_pin asserted asynchronously between clock edges while in MID → all outputs return to their reset values immediately, with no PM_wr.

Source files
------------

// File: rtl/zxw_pm_loader_if.sv
// Program-memory write port: address, 14-bit instruction word and one-cycle write strobe.
// The loader drives the master side; the program memory (or a bench) observes the slave side.
interface zxw_pm_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic [ADDR_W-1:0] PM_addr;
    logic [13:0]       PM_data;
    logic              PM_wr;

    modport master (output PM_addr, output PM_data, output PM_wr);
    modport slave  (input  PM_addr, input  PM_data, input  PM_wr);
endinterface

// File: rtl/zxw_pm_loader.sv
// Switch-driven program-memory writer: assembles 14-bit words from three 5-bit chunks and
// issues one-cycle writes, holding the CPU in reset while in load mode.
//
// state | meaning
// IDLE  | run mode, waiting for Mode to rise; address/Full kept for display
// HI    | waiting for chunk with bits [13:9] (ignored once Full)
// MID   | waiting for chunk with bits [8:4]
// LO    | waiting for chunk with bits [3:0]
// WRITE | PM_wr high for this one cycle, address advances on exit
module zxw_pm_loader #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 Clock_pin,
    input  logic                 Resetn_pin,
    input  logic [4:0]           SW_pin,
    input  logic                 Load_pin,
    input  logic                 Mode_pin,
    zxw_pm_loader_if.master      pm,
    output logic                 Cpu_resetn,
    output logic [7:0]           Display_pin
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        MID   = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_load_sync;
    logic [SYNC_STAGES-1:0]  r_mode_sync;
    logic                    r_load_prev;
    logic                    r_mode_prev;
    logic [ADDR_W-1:0]       r_pm_addr;
    logic [13:0]             r_pm_data;
    logic                    r_pm_wr;
    logic                    r_full;

    logic                    w_load_s;
    logic                    w_mode_s;
    logic                    w_load_edge;
    logic                    w_mode_rise;
    logic [1:0]              w_phase;

    assign w_load_s    = r_load_sync[SYNC_STAGES-1];
    assign w_mode_s    = r_mode_sync[SYNC_STAGES-1];
    assign w_load_edge = w_load_s & ~r_load_prev;
    assign w_mode_rise = w_mode_s & ~r_mode_prev;

    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_load_sync <= '0;
            r_mode_sync <= '0;
            r_load_prev <= 1'b0;
            r_mode_prev <= 1'b0;
        end else begin
            r_load_sync[0] <= Load_pin;
            r_mode_sync[0] <= Mode_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_load_sync[i] <= r_load_sync[i-1];
                r_mode_sync[i] <= r_mode_sync[i-1];
            end
            r_load_prev <= w_load_s;
            r_mode_prev <= w_mode_s;
        end
    end

    // Mode falling outside WRITE abandons the partial word; WRITE always finishes its pulse.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            r_state   <= IDLE;
            r_pm_addr <= '0;
            r_pm_data <= '0;
            r_pm_wr   <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mode_rise) begin
                        r_state   <= HI;
                        r_pm_addr <= '0;
                        r_full    <= 1'b0;
                    end
                end
                HI: begin
                    if (!w_mode_s) begin
                        r_state <= IDLE;
                    end else if (w_load_edge && !r_full) begin
                        r_pm_data[13:9] <= SW_pin;
                        r_state         <= MID;
                    end
                end
                MID: begin
                    if (!w_mode_s) begin
                        r_state <= IDLE;
                    end else if (w_load_edge) begin
                        r_pm_data[8:4] <= SW_pin;
                        r_state        <= LO;
                    end
                end
                LO: begin
                    if (!w_mode_s) begin
                        r_state <= IDLE;
                    end else if (w_load_edge) begin
                        r_pm_data[3:0] <= SW_pin[3:0];
                        r_pm_wr        <= 1'b1;
                        r_state        <= WRITE;
                    end
                end
                WRITE: begin
                    r_pm_wr <= 1'b0;
                    if (r_pm_addr == ADDR_W'(DEPTH - 1)) begin
                        r_full <= 1'b1;
                    end else begin
                        r_pm_addr <= r_pm_addr + ADDR_W'(1);
                    end
                    r_state <= w_mode_s ? HI : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_pm_wr <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_phase = 2'b00;
        case (r_state)
            IDLE:    w_phase = 2'b00;
            HI:      w_phase = 2'b01;
            MID:     w_phase = 2'b10;
            LO:      w_phase = 2'b11;
            WRITE:   w_phase = 2'b11;
            default: w_phase = 2'b00;
        endcase
    end

    assign pm.PM_addr  = r_pm_addr;
    assign pm.PM_data  = r_pm_data;
    assign pm.PM_wr    = r_pm_wr;
    assign Cpu_resetn  = Resetn_pin & ~w_mode_s;
    assign Display_pin = {r_full, w_phase, r_pm_addr[4:0]};

endmodule

// File: tb/tb_zxw_pm_loader.sv
// Bench for zxw_pm_loader: table-driven word loads, hand-written corner sequences and a
// randomized run compared against a word-level model of addresses, Full and expected writes.
module tb_zxw_pm_loader;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int SS     = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] sw = '0;
    logic       load = 1'b0;
    logic       mode = 1'b0;
    logic       cpu_resetn;
    logic [7:0] disp;

    zxw_pm_loader_if #(.ADDR_W(ADDR_W)) pm_if ();

    zxw_pm_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .SW_pin      (sw),
        .Load_pin    (load),
        .Mode_pin    (mode),
        .pm          (pm_if.master),
        .Cpu_resetn  (cpu_resetn),
        .Display_pin (disp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [13:0]       data;
    } wr_t;

    wr_t act_q[$];
    wr_t exp_q[$];

    // every sampled high cycle of PM_wr is one write; a stretched pulse shows up as extras
    always @(negedge clk) begin
        if (pm_if.PM_wr === 1'b1) act_q.push_back({pm_if.PM_addr, pm_if.PM_data});
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chunk(input logic [4:0] v, input int hi_c, input int lo_c);
        sw   = v;
        load = 1'b1;
        cycles(hi_c);
        load = 1'b0;
        cycles(lo_c);
    endtask

    task automatic load_word(input logic [13:0] w, input int hi_c, input int lo_c);
        logic b;
        b = 1'($urandom_range(0, 1));
        chunk(w[13:9], hi_c, lo_c);
        chunk(w[8:4], hi_c, lo_c);
        chunk({b, w[3:0]}, hi_c, lo_c);
    endtask

    typedef struct {
        logic [13:0]       word;
        bit                exp_wr;
        logic [ADDR_W-1:0] exp_addr;
        bit                exp_full;
        logic [4:0]        exp_disp_addr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n0;
        int k;
        logic [ADDR_W-1:0] m_addr;
        bit                m_full;
        logic [13:0]       w;

        vecs[0] = '{14'h0802, 1'b1, 10'd0, 1'b0, 5'd1};
        vecs[1] = '{14'h1FFF, 1'b1, 10'd1, 1'b0, 5'd2};
        vecs[2] = '{14'h0000, 1'b1, 10'd2, 1'b0, 5'd3};
        vecs[3] = '{14'h2AAA, 1'b1, 10'd3, 1'b1, 5'd3};
        vecs[4] = '{14'h1555, 1'b0, 10'd3, 1'b1, 5'd3};

        cycles(2);
        chk("rst_addr", pm_if.PM_addr, 0);
        chk("rst_data", pm_if.PM_data, 0);
        chk("rst_wr", pm_if.PM_wr, 0);
        chk("rst_disp", disp, 0);
        chk("rst_cpu_resetn", cpu_resetn, 0);

        rst_n = 1'b1;
        mode  = 1'b1;
        cycles(5);
        chk("enter_phase", disp[6:5], 2'b01);
        chk("enter_cpu_resetn", cpu_resetn, 0);

        foreach (vecs[i]) begin
            n0 = act_q.size();
            load_word(vecs[i].word, 4, 4);
            chk($sformatf("vec%0d_wr_count", i), act_q.size() - n0, vecs[i].exp_wr);
            if (vecs[i].exp_wr && act_q.size() > n0) begin
                chk($sformatf("vec%0d_addr", i), act_q[act_q.size()-1].addr, vecs[i].exp_addr);
                chk($sformatf("vec%0d_data", i), act_q[act_q.size()-1].data, vecs[i].word);
            end
            chk($sformatf("vec%0d_disp_addr", i), disp[4:0], vecs[i].exp_disp_addr);
            chk($sformatf("vec%0d_full", i), disp[7], vecs[i].exp_full);
            chk($sformatf("vec%0d_phase", i), disp[6:5], 2'b01);
            chk($sformatf("vec%0d_cpu_resetn", i), cpu_resetn, 0);
        end

        mode = 1'b0;
        cycles(5);
        chk("run_phase", disp[6:5], 2'b00);
        chk("run_full_kept", disp[7], 1);
        chk("run_addr_kept", disp[4:0], 3);
        chk("run_cpu_resetn", cpu_resetn, 1);
        mode = 1'b1;
        cycles(5);
        chk("reenter_phase", disp[6:5], 2'b01);
        chk("reenter_full", disp[7], 0);
        chk("reenter_addr", disp[4:0], 0);

        n0 = act_q.size();
        chunk(5'h15, 4, 4);
        chunk(5'h0A, 4, 4);
        chk("partial_phase_lo", disp[6:5], 2'b11);
        mode = 1'b0;
        k = 0;
        while (cpu_resetn !== 1'b1 && k < 6) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("cpu_release_latency_ok", (k <= SS + 1), 1);
        @(negedge clk);
        cycles(3);
        chk("partial_no_write", act_q.size() - n0, 0);
        chk("partial_idle", disp[6:5], 2'b00);
        mode = 1'b1;
        cycles(5);
        chk("partial_reenter_addr", pm_if.PM_addr, 0);
        n0 = act_q.size();
        load_word(14'h3C3C, 4, 4);
        chk("after_partial_wr_count", act_q.size() - n0, 1);
        if (act_q.size() > n0) begin
            chk("after_partial_addr", act_q[act_q.size()-1].addr, 0);
            chk("after_partial_data", act_q[act_q.size()-1].data, 14'h3C3C);
        end

        sw   = 5'h1F;
        load = 1'b1;
        cycles(20);
        load = 1'b0;
        cycles(4);
        chk("held_load_one_chunk", disp[6:5], 2'b10);
        sw = 5'h0A;
        #3 load = 1'b1;
        #4 load = 1'b0;
        @(negedge clk);
        cycles(4);
        chk("short_pulse_one_chunk", disp[6:5], 2'b11);
        n0 = act_q.size();
        chunk(5'h15, 4, 4);
        chk("held_short_wr_count", act_q.size() - n0, 1);
        if (act_q.size() > n0) begin
            chk("held_short_addr", act_q[act_q.size()-1].addr, 1);
            chk("held_short_data", act_q[act_q.size()-1].data, 14'h3EA5);
        end

        chunk(5'h11, 4, 4);
        chk("mid_before_reset", disp[6:5], 2'b10);
        n0 = act_q.size();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_addr", pm_if.PM_addr, 0);
        chk("async_rst_data", pm_if.PM_data, 0);
        chk("async_rst_wr", pm_if.PM_wr, 0);
        chk("async_rst_disp", disp, 0);
        chk("async_rst_cpu_resetn", cpu_resetn, 0);
        @(negedge clk);
        cycles(2);
        chk("async_rst_no_write", act_q.size() - n0, 0);
        mode  = 1'b0;
        rst_n = 1'b1;
        cycles(3);

        act_q.delete();
        exp_q.delete();
        mode = 1'b1;
        cycles(5);
        m_addr = '0;
        m_full = 1'b0;
        for (int it = 0; it < 40; it++) begin
            w = 14'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(0, 2);
                for (int c = 0; c < k; c++) chunk(5'($urandom), 4, 4);
                mode = 1'b0;
                cycles(5);
                mode = 1'b1;
                cycles(5);
                m_addr = '0;
                m_full = 1'b0;
            end else begin
                load_word(w, $urandom_range(3, 8), $urandom_range(4, 7));
                if (!m_full) begin
                    exp_q.push_back({m_addr, w});
                    if (int'(m_addr) == DEPTH - 1) m_full = 1'b1;
                    else m_addr = m_addr + 1'b1;
                end
            end
        end
        cycles(2);
        chk("rand_write_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("rand_addr_%0d", i), act_q[i].addr, exp_q[i].addr);
            chk($sformatf("rand_data_%0d", i), act_q[i].data, exp_q[i].data);
        end
        chk("rand_final_addr", disp[4:0], m_addr[4:0]);
        chk("rand_final_full", disp[7], m_full);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1);
    end
endmodule
